// File: rtl/clock_select_sequencer_pkg.sv
// Shared definitions for the clock-select sequencer: state encodings, the default
// synchroniser depth, and helpers that derive the registered outputs from a state.
package clock_select_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HS      = 3'd0,
        ST_TO_LS   = 3'd1,
        ST_LS      = 3'd2,
        ST_LS_HOLD = 3'd3,
        ST_TO_HS   = 3'd4
    } cs_state_e;

    localparam int DEFAULT_SYNC_STAGES = 2;

    function automatic logic state_selects_hs(input cs_state_e s);
        return (s == ST_HS) || (s == ST_TO_HS);
    endfunction

    // CPU may run only when a clock is settled, never while a switch is in flight
    function automatic logic state_is_ready(input cs_state_e s);
        return (s == ST_HS) || (s == ST_LS) || (s == ST_LS_HOLD);
    endfunction

endpackage

// File: rtl/bit_synchroniser.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module bit_synchroniser #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/clock_select_sequencer.sv
// Sequences the glitch-free clock switch between the fast clock and the 2MHz host clock,
// stalling the CPU while a switch is in flight. Optional switch watchdog: SWITCH_TIMEOUT_EN.
module clock_select_sequencer
    import clock_select_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES      = DEFAULT_SYNC_STAGES,
    parameter int SLOW_HOLD_CYCLES = 4,
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int CNT_W            = 8
) (
    input  logic       hs_ck_ip,
    input  logic       reset_ip,
    input  logic       slow_req_ip,
    input  logic       force_slow_ip,
    input  logic       selected_hs_ip,
    input  logic       selected_ls_ip,
    input  logic       timeout_clr_ip,
    output logic       select_hs_op,
    output logic       rdy_op,
    output logic [2:0] state_op,
    output logic       timeout_op
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(SLOW_HOLD_CYCLES - 1);

    cs_state_e        state_q, state_d;
    logic             select_hs_q;
    logic             rdy_q;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic hs_sync, ls_sync;
    logic hs_ok, ls_ok;
    logic want_ls;
    logic switch_done;
    logic timeout_fire;

    bit_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_hs (
        .clk (hs_ck_ip),
        .rst (reset_ip),
        .d   (selected_hs_ip),
        .q   (hs_sync)
    );

    bit_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_ls (
        .clk (hs_ck_ip),
        .rst (reset_ip),
        .d   (selected_ls_ip),
        .q   (ls_sync)
    );

    // Exactly one status flag must be set before a switch counts as complete
    assign hs_ok   = hs_sync & ~ls_sync;
    assign ls_ok   = ls_sync & ~hs_sync;
    assign want_ls = slow_req_ip | force_slow_ip;

    assign switch_done = ((state_q == ST_TO_LS) && ls_ok) ||
                         ((state_q == ST_TO_HS) && hs_ok);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_HS: begin
                if (want_ls) state_d = ST_TO_LS;
            end
            ST_TO_LS: begin
                if (ls_ok) state_d = ST_LS;
            end
            ST_LS: begin
                if (!want_ls) begin
                    state_d    = ST_LS_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_LS_HOLD: begin
                if (want_ls) begin
                    state_d = ST_LS;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_TO_HS;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            // A slow request here waits for the switch to land, then leaves via ST_HS
            ST_TO_HS: begin
                if (hs_ok) state_d = ST_HS;
            end
            default: begin
                state_d = ST_TO_LS;
            end
        endcase
        if (timeout_fire) begin
            state_d = ST_TO_LS;
        end
    end

    // Outputs are registered from the next state, so select_hs only moves on state entry
    always_ff @(posedge hs_ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            state_q     <= ST_TO_LS;
            select_hs_q <= 1'b0;
            rdy_q       <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            select_hs_q <= state_selects_hs(state_d);
            rdy_q       <= state_is_ready(state_d);
            hold_cnt_q  <= hold_cnt_d;
        end
    end

`ifdef SWITCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             timeout_q;
    logic             in_switch;

    assign in_switch    = (state_q == ST_TO_LS) || (state_q == ST_TO_HS);
    assign timeout_fire = in_switch && !switch_done && (to_cnt_q == TIMEOUT_LAST);
    assign to_cnt_d     = (in_switch && !switch_done && !timeout_fire) ?
                          to_cnt_q + CNT_W'(1) : '0;

    // A new timeout takes priority over a clear in the same cycle
    always_ff @(posedge hs_ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if (timeout_fire) begin
                timeout_q <= 1'b1;
            end else if (timeout_clr_ip) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout_op = timeout_q;
`else
    logic unused_timeout;

    assign timeout_fire   = 1'b0;
    assign timeout_op     = 1'b0;
    assign unused_timeout = timeout_clr_ip | switch_done | (TIMEOUT_CYCLES == 0);
`endif

    // Combinational mask so a slow access never completes on the fast clock
    assign rdy_op       = rdy_q & ~((state_q == ST_HS) & want_ls);
    assign select_hs_op = select_hs_q;
    assign state_op     = state_q;

endmodule

// File: tb/tb_clock_select_sequencer.sv
// Directed bench for clock_select_sequencer with a hand-driven clock switch model.
module tb_clock_select_sequencer;
    import clock_select_sequencer_pkg::*;

    localparam int SYNC = 2;
    localparam int HOLD = 4;
    localparam int TOC  = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       slow_req = 1'b0;
    logic       force_sl = 1'b0;
    logic       hs_in    = 1'b0;
    logic       ls_in    = 1'b0;
    logic       clr      = 1'b0;
    logic       sel_hs;
    logic       rdy;
    logic [2:0] state;
    logic       tout;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       sel;
        logic       rdy;
        logic       to;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_to = 1'b0;

    always #5 clk = ~clk;

    clock_select_sequencer #(
        .SYNC_STAGES      (SYNC),
        .SLOW_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES   (TOC),
        .CNT_W            (8)
    ) dut (
        .hs_ck_ip       (clk),
        .reset_ip       (rst),
        .slow_req_ip    (slow_req),
        .force_slow_ip  (force_sl),
        .selected_hs_ip (hs_in),
        .selected_ls_ip (ls_in),
        .timeout_clr_ip (clr),
        .select_hs_op   (sel_hs),
        .rdy_op         (rdy),
        .state_op       (state),
        .timeout_op     (tout)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expectation, advance (one edge or a settle delay), then pop and compare
    task automatic step(input string tag, input logic [2:0] st, input logic sel,
                        input logic rdy_e, input bit edge_wait);
        exp_t e;
        sbq.push_back('{tag, st, sel, rdy_e, exp_to});
        if (edge_wait) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
        e = sbq.pop_front();
        chk({e.tag, "/state"}, 8'(state),  8'(e.st));
        chk({e.tag, "/sel"},   8'(sel_hs), 8'(e.sel));
        chk({e.tag, "/rdy"},   8'(rdy),    8'(e.rdy));
        chk({e.tag, "/tout"},  8'(tout),   8'(e.to));
    endtask

    task automatic hold_to_hs(input string tag);
        repeat (HOLD) step({tag, "_hold"}, ST_LS_HOLD, 1'b0, 1'b1, 1'b1);
        step({tag, "_tohs"}, ST_TO_HS, 1'b1, 1'b0, 1'b1);
    endtask

    // Break-before-make switch model: drop the old flag, wait, raise the new one
    task automatic complete_switch(input string tag, input bit to_hs, input int delay,
                                   input logic fin_rdy);
        logic [2:0] tr;
        logic [2:0] fin;
        tr  = to_hs ? ST_TO_HS : ST_TO_LS;
        fin = to_hs ? ST_HS : ST_LS;
        if (to_hs) ls_in = 1'b0; else hs_in = 1'b0;
        repeat (delay) step({tag, "_dly"}, tr, to_hs, 1'b0, 1'b1);
        if (to_hs) hs_in = 1'b1; else ls_in = 1'b1;
        repeat (SYNC) step({tag, "_sync"}, tr, to_hs, 1'b0, 1'b1);
        step({tag, "_done"}, fin, to_hs, fin_rdy, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step("rst0", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        step("rst1", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        rst      = 1'b0;
        slow_req = 1'b1;

        // Initial switch to the slow clock: ls flag 3 cycles after reset release
        repeat (3) step("t1_wait", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        ls_in = 1'b1;
        repeat (SYNC) step("t1_sync", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        step("t1_ls", ST_LS, 1'b0, 1'b1, 1'b1);
        step("t1_stay", ST_LS, 1'b0, 1'b1, 1'b1);

        // Hold hysteresis: re-request on hold cycle 2, then a full hold expiry
        slow_req = 1'b0;
        step("t3_h1", ST_LS_HOLD, 1'b0, 1'b1, 1'b1);
        step("t3_h2", ST_LS_HOLD, 1'b0, 1'b1, 1'b1);
        slow_req = 1'b1;
        step("t3_back", ST_LS, 1'b0, 1'b1, 1'b1);
        slow_req = 1'b0;
        hold_to_hs("t3");
        complete_switch("t3_sw", 1'b1, 3, 1'b1);

        // Slow request from ST_HS: ready masked at once, select drops on next edge
        slow_req = 1'b1;
        step("t2_mask", ST_HS, 1'b1, 1'b0, 1'b0);
        step("t2_tols", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        complete_switch("t2_sw", 1'b0, 6, 1'b1);

        // force_slow alone holds the slow clock
        slow_req = 1'b0;
        hold_to_hs("t4a");
        complete_switch("t4a_sw", 1'b1, 2, 1'b1);
        force_sl = 1'b1;
        step("t4_mask", ST_HS, 1'b1, 1'b0, 1'b0);
        step("t4_tols", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        complete_switch("t4_sw", 1'b0, 3, 1'b1);
        repeat (100) step("t4_stay", ST_LS, 1'b0, 1'b1, 1'b1);
        force_sl = 1'b0;
        hold_to_hs("t4b");
        complete_switch("t4b_sw", 1'b1, 2, 1'b1);

        // Slow request during ST_TO_HS: no abort, land in ST_HS masked, then leave
        slow_req = 1'b1;
        step("t5_tols", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        complete_switch("t5_ls", 1'b0, 2, 1'b1);
        slow_req = 1'b0;
        hold_to_hs("t5");
        slow_req = 1'b1;
        repeat (2) step("t5_wait", ST_TO_HS, 1'b1, 1'b0, 1'b1);
        complete_switch("t5_sw", 1'b1, 0, 1'b0);
        step("t5_leave", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        complete_switch("t5_back", 1'b0, 2, 1'b1);

        // Stuck switch toward the fast clock
        slow_req = 1'b0;
        hold_to_hs("t6");
`ifdef SWITCH_TIMEOUT_EN
        repeat (TOC - 1) step("t6_wait", ST_TO_HS, 1'b1, 1'b0, 1'b1);
        exp_to   = 1'b1;
        slow_req = 1'b1;
        step("t6_fire", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        step("t6_ls", ST_LS, 1'b0, 1'b1, 1'b1);
        step("t6_sticky", ST_LS, 1'b0, 1'b1, 1'b1);
        clr    = 1'b1;
        exp_to = 1'b0;
        step("t6_clr", ST_LS, 1'b0, 1'b1, 1'b1);
        clr = 1'b0;
        step("t6_clred", ST_LS, 1'b0, 1'b1, 1'b1);
        slow_req = 1'b0;
        hold_to_hs("t6b");
`else
        clr = 1'b1;
        step("t6_clr_ign", ST_TO_HS, 1'b1, 1'b0, 1'b1);
        clr = 1'b0;
        repeat (40) step("t6_forever", ST_TO_HS, 1'b1, 1'b0, 1'b1);
`endif

        // Asynchronous reset mid-switch, then synchronisers must refill from zero
        slow_req = 1'b1;
        exp_to   = 1'b0;
        #3 rst = 1'b1;
        step("rst_mid", ST_TO_LS, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        repeat (SYNC) step("rst_sync", ST_TO_LS, 1'b0, 1'b0, 1'b1);
        step("rst_ls", ST_LS, 1'b0, 1'b1, 1'b1);

        chk("sb_empty", 8'(sbq.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
